// File: rtl/ccu_pkg.sv
// Shared definitions for the CCU sequencer: opcodes, FSM states, field positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ccu_pkg;

  localparam int INSTR_W = 24;

  // Instruction field positions: [23:20] op, [19:16] A, [15:12] B, [11:8] R, [7:0] imm
  localparam int OP_MSB  = 23;
  localparam int OP_LSB  = 20;
  localparam int A_MSB   = 19;
  localparam int A_LSB   = 16;
  localparam int B_MSB   = 15;
  localparam int B_LSB   = 12;
  localparam int R_MSB   = 11;
  localparam int R_LSB   = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes 0-7 are ALU ops passed straight to the datapath; 13-15 are NOPs
  localparam logic [3:0] OP_LDI  = 4'd8;
  localparam logic [3:0] OP_OUT  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_BRZ  = 4'd11;
  localparam logic [3:0] OP_HALT = 4'd12;

  // Idle value of the opcode bus: not a load-immediate
  localparam logic [3:0] N_IDLE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    SETTLE,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LDI,
    CL_OUT,
    CL_JMP,
    CL_BRZ,
    CL_HALT,
    CL_NOP
  } op_class_t;

endpackage

// File: rtl/ccu_if.sv
// Bundle of the sequencer's program-memory and datapath-control signals.
// Latency: n/a (wiring only).
// Backpressure: none; master = sequencer side, slave = program memory + datapath side.
interface ccu_if #(
  parameter int PC_W = 8
);

  logic [PC_W-1:0]             pc_addr;
  logic [ccu_pkg::INSTR_W-1:0] instr;
  logic [3:0]                  abus;
  logic [3:0]                  bbus;
  logic [3:0]                  rbus;
  logic [3:0]                  n;
  logic [7:0]                  mdata;
  logic                        out_enable;
  logic [3:0]                  cc;

  modport master (
    output pc_addr, abus, bbus, rbus, n, mdata, out_enable,
    input  instr, cc
  );

  modport slave (
    input  pc_addr, abus, bbus, rbus, n, mdata, out_enable,
    output instr, cc
  );

endinterface

// File: rtl/ccu_decode.sv
// Combinational instruction decoder: splits a program word into class and fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_instr program word in; o_class op class, o_op/o_a/o_b/o_r/o_imm raw fields out.
module ccu_decode
  import ccu_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output op_class_t          o_class,
  output logic [3:0]         o_op,
  output logic [3:0]         o_a,
  output logic [3:0]         o_b,
  output logic [3:0]         o_r,
  output logic [7:0]         o_imm
);

  assign o_op  = i_instr[OP_MSB:OP_LSB];
  assign o_a   = i_instr[A_MSB:A_LSB];
  assign o_b   = i_instr[B_MSB:B_LSB];
  assign o_r   = i_instr[R_MSB:R_LSB];
  assign o_imm = i_instr[IMM_MSB:IMM_LSB];

  always_comb begin
    o_class = CL_NOP;
    if (o_op < OP_LDI) begin
      o_class = CL_ALU;
    end else begin
      case (o_op)
        OP_LDI:  o_class = CL_LDI;
        OP_OUT:  o_class = CL_OUT;
        OP_JMP:  o_class = CL_JMP;
        OP_BRZ:  o_class = CL_BRZ;
        OP_HALT: o_class = CL_HALT;
        default: o_class = CL_NOP;
      endcase
    end
  end

endmodule

// File: rtl/ccu_sequencer.sv
// Microcoded datapath sequencer: fetches 24-bit words and drives datapath control.
// Latency: 3 cycles per ALU/LDI/OUT/NOP (FETCH, EXEC, SETTLE), 2 per JMP/BRZ; done 1 cycle after HALT exec.
// Backpressure: none; start is ignored unless idle.
// Ports: clk/rst_n; start/busy/done control; pc_addr -> program memory, instr <- memory (1-cycle read);
//        abus/bbus/rbus/n/mdata/out_enable -> datapath; cc <- datapath flags {N,Z,V,C}.
module ccu_sequencer
  import ccu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [PC_W-1:0]     pc_addr,
  input  logic [INSTR_W-1:0]  instr,
  output logic [3:0]          abus,
  output logic [3:0]          bbus,
  output logic [3:0]          rbus,
  output logic [3:0]          n,
  output logic [7:0]          mdata,
  output logic                out_enable,
  input  logic [3:0]          cc
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_z_flag;
  logic            r_z_upd;   // current op is allowed to refresh z_flag in SETTLE
  logic            r_busy;
  logic            r_done;
  logic            r_out_en;
  logic [3:0]      r_abus;
  logic [3:0]      r_bbus;
  logic [3:0]      r_rbus;
  logic [3:0]      r_n;
  logic [7:0]      r_mdata;

  op_class_t       w_class;
  logic [3:0]      w_op;
  logic [3:0]      w_a;
  logic [3:0]      w_b;
  logic [3:0]      w_r;
  logic [7:0]      w_imm;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_unused_cc;

  ccu_decode u_decode (
    .i_instr (instr),
    .o_class (w_class),
    .o_op    (w_op),
    .o_a     (w_a),
    .o_b     (w_b),
    .o_r     (w_r),
    .o_imm   (w_imm)
  );

  // Branch target is the immediate resized to the pc width
  assign w_target = PC_W'(w_imm);
  // Natural wrap at 2^PC_W
  assign w_pc_inc = r_pc + PC_W'(1);
  // Only Z participates in branching
  assign w_unused_cc = ^{cc[3], cc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_z_flag <= 1'b0;
      r_z_upd  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_out_en <= 1'b0;
      r_abus   <= 4'h0;
      r_bbus   <= 4'h0;
      r_rbus   <= 4'h0;
      r_n      <= N_IDLE;
      r_mdata  <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pc    <= '0;
            r_busy  <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          // pc_addr already presents r_pc; the word arrives next cycle
          r_state <= EXEC;
        end
        EXEC: begin
          r_z_upd <= 1'b0;
          r_state <= SETTLE;
          case (w_class)
            CL_ALU: begin
              r_abus  <= w_a;
              r_bbus  <= w_b;
              r_rbus  <= w_r;
              r_n     <= w_op;
              r_z_upd <= 1'b1;
            end
            CL_LDI: begin
              r_n     <= OP_LDI;
              r_rbus  <= w_r;
              r_mdata <= w_imm;
              r_z_upd <= 1'b1;
            end
            CL_OUT: r_out_en <= ~r_out_en;
            CL_JMP: begin
              r_pc    <= w_target;
              r_state <= FETCH;
            end
            CL_BRZ: begin
              r_pc    <= r_z_flag ? w_target : w_pc_inc;
              r_state <= FETCH;
            end
            CL_HALT: begin
              // done is visible for exactly the one cycle spent in HALT
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= HALT;
            end
            default: ;
          endcase
        end
        SETTLE: begin
          if (r_z_upd) begin
            r_z_flag <= cc[2];
          end
          r_pc    <= w_pc_inc;
          r_state <= FETCH;
        end
        HALT: begin
          // start arriving alongside done is dropped here on purpose
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pc_addr    = r_pc;
  assign abus       = r_abus;
  assign bbus       = r_bbus;
  assign rbus       = r_rbus;
  assign n          = r_n;
  assign mdata      = r_mdata;
  assign out_enable = r_out_en;

endmodule

// File: tb/tb_ccu_sequencer.sv
// Testbench for ccu_sequencer: table of small programs plus hand-written timing sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_ccu_sequencer;
  import ccu_pkg::*;

  localparam int PC_W = 8;
  localparam logic [23:0] H = 24'hC00000;  // HALT word

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  ccu_if #(.PC_W(PC_W)) bus ();

  ccu_sequencer #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pc_addr    (bus.pc_addr),
    .instr      (bus.instr),
    .abus       (bus.abus),
    .bbus       (bus.bbus),
    .rbus       (bus.rbus),
    .n          (bus.n),
    .mdata      (bus.mdata),
    .out_enable (bus.out_enable),
    .cc         (bus.cc)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM: word valid one cycle after the address
  logic [23:0] mem [256];
  always @(posedge clk) bus.instr <= mem[bus.pc_addr];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [23:0] p0, p1, p2, p3;
    logic [3:0]  cc;
    int          done_cyc;
    logic [3:0]  a, b, r, nn;
    logic [7:0]  m;
    logic        oe;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [23:0] p0, logic [23:0] p1, logic [23:0] p2, logic [23:0] p3,
                              logic [3:0] c, int dc, logic [3:0] a, logic [3:0] b, logic [3:0] r,
                              logic [3:0] nn, logic [7:0] m, logic oe);
    vec_t v;
    v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.cc = c; v.done_cyc = dc;
    v.a = a; v.b = b; v.r = r; v.nn = nn; v.m = m; v.oe = oe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_prog(input logic [23:0] p0, input logic [23:0] p1,
                           input logic [23:0] p2, input logic [23:0] p3);
    for (int k = 0; k < 256; k++) mem[k] = H;
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
  endtask

  // Pulse start for one edge; cyc = 1 is the first cycle after start is sampled
  task automatic start_prog();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && cyc < 100) tick();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    do_reset();
    load_prog(v.p0, v.p1, v.p2, v.p3);
    bus.cc = v.cc;
    start_prog();
    wait_done();
    chk($sformatf("v%0d_done_cycle", idx), cyc, v.done_cyc);
    chk($sformatf("v%0d_busy_at_done", idx), {31'd0, busy}, 0);
    tick();
    chk($sformatf("v%0d_done_width", idx), {31'd0, done}, 0);
    chk($sformatf("v%0d_abus", idx), bus.abus, v.a);
    chk($sformatf("v%0d_bbus", idx), bus.bbus, v.b);
    chk($sformatf("v%0d_rbus", idx), bus.rbus, v.r);
    chk($sformatf("v%0d_n", idx), bus.n, v.nn);
    chk($sformatf("v%0d_mdata", idx), bus.mdata, v.m);
    chk($sformatf("v%0d_out_enable", idx), {31'd0, bus.out_enable}, {31'd0, v.oe});
  endtask

  task automatic brz_case(input logic [3:0] c, input logic [7:0] exp_pc);
    do_reset();
    load_prog(24'h112300, 24'hB00005, H, H);
    bus.cc = c;
    start_prog();
    tick(); tick(); tick();
    chk($sformatf("brz_cc%0h_pc_at_brz", c), bus.pc_addr, 8'h01);
    tick(); tick();
    chk($sformatf("brz_cc%0h_next_pc", c), bus.pc_addr, exp_pc);
    wait_done();
  endtask

  initial begin
    int bad;

    bus.cc = 4'h0;
    //            p0          p1          p2  p3          cc    done a     b     r     n     mdata  oe
    vecs[0]  = mk(24'h3CD100, 24'h900000, H,  H,          4'h0, 9,  4'hC, 4'hD, 4'h1, 4'h3, 8'h00, 1'b1);
    vecs[1]  = mk(24'h800912, H,          H,  H,          4'h0, 6,  4'h0, 4'h0, 4'h9, 4'h8, 8'h12, 1'b0);
    vecs[2]  = mk(24'h900000, 24'h900000, H,  H,          4'h0, 9,  4'h0, 4'h0, 4'h0, 4'hF, 8'h00, 1'b0);
    vecs[3]  = mk(24'hD12345, H,          H,  H,          4'h0, 6,  4'h0, 4'h0, 4'h0, 4'hF, 8'h00, 1'b0);
    vecs[4]  = mk(24'hA00003, H,          H,  24'h800255, 4'h0, 8,  4'h0, 4'h0, 4'h2, 4'h8, 8'h55, 1'b0);
    vecs[5]  = mk(24'h112300, 24'hB00003, H,  24'h800466, 4'h4, 11, 4'h1, 4'h2, 4'h4, 4'h8, 8'h66, 1'b0);
    vecs[6]  = mk(24'h112300, 24'hB00003, H,  24'h800466, 4'h0, 8,  4'h1, 4'h2, 4'h3, 4'h1, 8'h00, 1'b0);
    vecs[7]  = mk(24'hB00003, H,          H,  24'h800466, 4'h4, 5,  4'h0, 4'h0, 4'h0, 4'hF, 8'h00, 1'b0);
    vecs[8]  = mk(H,          H,          H,  H,          4'h0, 3,  4'h0, 4'h0, 4'h0, 4'hF, 8'h00, 1'b0);
    vecs[9]  = mk(24'hFABCDE, H,          H,  H,          4'h0, 6,  4'h0, 4'h0, 4'h0, 4'hF, 8'h00, 1'b0);
    vecs[10] = mk(24'h7FED12, H,          H,  H,          4'hB, 6,  4'hF, 4'hE, 4'hD, 4'h7, 8'h00, 1'b0);

    // Reset values
    load_prog(H, H, H, H);
    do_reset();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pc_addr", bus.pc_addr, 0);
    chk("rst_abus", bus.abus, 0);
    chk("rst_bbus", bus.bbus, 0);
    chk("rst_rbus", bus.rbus, 0);
    chk("rst_n_idle", bus.n, 4'hF);
    chk("rst_mdata", bus.mdata, 0);
    chk("rst_out_enable", {31'd0, bus.out_enable}, 0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // LDI timing: busy rises with start, datapath fields appear after EXEC and hold
    do_reset();
    load_prog(24'h800912, H, H, H);
    start_prog();
    chk("ldi_busy_c1", {31'd0, busy}, 1);
    chk("ldi_pc_c1", bus.pc_addr, 0);
    tick();
    chk("ldi_n_c2", bus.n, 4'hF);
    tick();
    chk("ldi_n_c3", bus.n, 4'h8);
    chk("ldi_rbus_c3", bus.rbus, 4'h9);
    chk("ldi_mdata_c3", bus.mdata, 8'h12);
    tick();
    chk("ldi_n_c4", bus.n, 4'h8);
    chk("ldi_pc_c4", bus.pc_addr, 1);
    wait_done();
    chk("ldi_done_c6", cyc, 6);
    tick();
    chk("ldi_busy_after", {31'd0, busy}, 0);

    // ALU hold and single OUT toggle
    do_reset();
    load_prog(24'h3CD100, 24'h900000, H, H);
    start_prog();
    tick(); tick();
    chk("alu_n_c3", bus.n, 4'h3);
    chk("alu_abus_c3", bus.abus, 4'hC);
    chk("alu_bbus_c3", bus.bbus, 4'hD);
    chk("alu_rbus_c3", bus.rbus, 4'h1);
    tick();
    chk("alu_n_c4", bus.n, 4'h3);
    chk("alu_abus_c4", bus.abus, 4'hC);
    tick();
    chk("out_c5", {31'd0, bus.out_enable}, 0);
    tick();
    chk("out_c6", {31'd0, bus.out_enable}, 1);
    chk("out_n_unchanged", bus.n, 4'h3);
    wait_done();
    tick();
    chk("out_after_halt", {31'd0, bus.out_enable}, 1);

    // BRZ taken / not taken on Z captured in the preceding SETTLE
    brz_case(4'b0100, 8'h05);
    brz_case(4'b0000, 8'h02);

    // JMP to last address then wrap on increment
    do_reset();
    load_prog(24'hA000FF, H, H, H);
    mem[255] = 24'hD00000;
    start_prog();
    tick(); tick();
    chk("wrap_pc_ff", bus.pc_addr, 8'hFF);
    tick(); tick(); tick();
    chk("wrap_pc_00", bus.pc_addr, 8'h00);

    // Reset during SETTLE aborts immediately, no done, start needed afterwards
    do_reset();
    load_prog(24'h800912, H, H, H);
    start_prog();
    tick(); tick();
    chk("abort_pre_n", bus.n, 4'h8);
    rst_n = 1'b0;
    #1;
    chk("abort_n", bus.n, 4'hF);
    chk("abort_rbus", bus.rbus, 0);
    chk("abort_mdata", bus.mdata, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_pc", bus.pc_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || bus.pc_addr !== 8'h00) bad++;
    end
    chk("abort_idle_quiet", bad, 0);
    start_prog();
    chk("restart_pc", bus.pc_addr, 0);
    chk("restart_busy", {31'd0, busy}, 1);
    wait_done();
    chk("restart_done_c6", cyc, 6);

    // start while busy and start alongside done are both ignored
    do_reset();
    load_prog(24'hD00000, 24'hD00000, 24'hD00000, H);
    start_prog();
    bad = 0;
    while (cyc <= 16) begin
      if (cyc == 1)  chk("sb_pc_c1", bus.pc_addr, 0);
      if (cyc == 4)  chk("sb_pc_c4", bus.pc_addr, 1);
      if (cyc == 7)  chk("sb_pc_c7", bus.pc_addr, 2);
      if (cyc == 10) chk("sb_pc_c10", bus.pc_addr, 3);
      if (cyc == 12) chk("sb_done_c12", {31'd0, done}, 1);
      if (cyc != 12 && done !== 1'b0) bad++;
      if (cyc > 12 && busy !== 1'b0) bad++;
      start = (cyc == 2 || cyc == 4 || cyc == 12);
      tick();
    end
    start = 1'b0;
    chk("sb_no_restart", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccu_sequencer.md
CCU_SEQUENCER -- requirements
Module: ccu_sequencer

Interface
REQ-001 The parameter list SHALL be: PC_W, default 8, program-address width.
REQ-002 The port list SHALL be, in order:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  one-cycle pulse that starts program execution at address 0.
- busy  output  1  high while a program is executing.
- done  output  1  one-cycle pulse when HALT retires.
- pc_addr  output  PC_W  program memory address.
- instr  input  24  program word; valid one cycle after pc_addr is driven.
- abus  output  4  datapath A operand register index.
- bbus  output  4  datapath B operand register index.
- rbus  output  4  datapath result register index.
- n  output  4  datapath opcode.
- mdata  output  8  immediate value for load-immediate.
- out_enable  output  1  video-out trigger; toggles once per OUT instruction.
- cc  input  4  datapath condition codes {N,Z,V,C}; Z is cc[2].
REQ-003 The instruction format SHALL be [23:20] op, [19:16] A, [15:12] B, [11:8] R, [7:0] imm.

Function
REQ-004 The states SHALL be IDLE, FETCH, EXEC, SETTLE and HALT.
REQ-005 In IDLE, start=1 SHALL clear pc to 0 and go to FETCH; busy SHALL rise in the same edge.
REQ-006 FETCH SHALL drive pc_addr=pc and go to EXEC next cycle.
REQ-007 EXEC SHALL register instr and decode it.
REQ-008 Op 0-7 (ALU): abus/bbus/rbus/n SHALL take A/B/R/op and be held through SETTLE.
REQ-009 Op 8 (load-immediate): n=8, rbus=R, mdata=imm SHALL be held through SETTLE.
REQ-010 Op 9 (OUT) SHALL toggle out_enable exactly once; the datapath outputs SHALL be unchanged.
REQ-011 Op 10 (JMP) SHALL set pc to imm[PC_W-1:0] and go straight to FETCH, skipping SETTLE.
REQ-012 Op 11 (BRZ) SHALL take the branch to imm when the cc[2] sampled in the previous SETTLE is 1; otherwise pc increments. It goes straight to FETCH.
REQ-013 Op 12 (HALT) SHALL enter HALT; the next cycle SHALL pulse done for 1 cycle, drop busy and return to IDLE.
REQ-014 Ops 13-15 SHALL be NOPs: pc increments and the datapath outputs are unchanged.
REQ-015 SETTLE SHALL last exactly 1 cycle. On leaving it, cc SHALL be captured into z_flag, pc SHALL increment and the state SHALL return to FETCH.
REQ-016 Throughput SHALL be 3 cycles per datapath/OUT/NOP instruction and 2 cycles per JMP/BRZ.
REQ-017 The pc SHALL wrap modulo 2^PC_W (all-ones + 1 = 0) without error.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 start in the same cycle as done SHALL be ignored; a new start is accepted from the first IDLE cycle.
REQ-020 Outside an active datapath op, abus, bbus, rbus, n and mdata SHALL hold their last values; no glitch values are permitted.
REQ-021 z_flag SHALL be updated only by SETTLE of ops 0-8.

Reset
REQ-022 When rst_n=0, the block SHALL asynchronously set state=IDLE, pc=0, z_flag=0, and busy, done, out_enable, abus, bbus, rbus and mdata to 0.
REQ-023 When rst_n=0, n SHALL reset to 4'hF so that the datapath sees no load-immediate.
REQ-024 Reset asserted mid-program SHALL abort it with no done pulse.
REQ-025 After reset deassertion, start SHALL be required before any fetch.

Structure
REQ-026 Package ccu_pkg SHALL hold the opcode constants (OP_LDI=8, OP_OUT=9, OP_JMP=10, OP_BRZ=11, OP_HALT=12), the state enum and the instruction field bit positions.
REQ-027 The combinational decoder SHALL be sub-module ccu_decode: instr in, op class and field outputs out.
REQ-028 All sequential logic SHALL reside in ccu_sequencer.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Program {LDI R9=0x12, HALT}, start → n=8, rbus=9, mdata=0x12 in EXEC; done pulses on cycle 6 after start; busy low afterwards.
- Program {ALU op 3 A=12 B=13 R=1, OUT, HALT} → n=3/abus=12/bbus=13/rbus=1 held 2 cycles; out_enable toggles 0→1 once.
- BRZ with cc=4'b0100 in the prior SETTLE, imm=0x05 → next pc_addr=5. With cc=0 → pc_addr=prior+1.
- JMP imm=0xFF at last address, then pc increment → pc_addr goes 0xFF then 0x00 (wrap).
- rst_n low during SETTLE → all outputs at their reset values immediately (n=0xF); no done pulse; second start restarts at address 0.
- start pulsed while busy → ignored; pc sequence unchanged.
